// File: rtl/alu_exec.sv
// 16-bit execute-stage ALU. Single-cycle ops are registered at the accepting edge.
// MUL is an iterative shift-add that blocks new operations for 16 cycles.
module alu_exec (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_in,
    input  logic [3:0]  alu_func,
    input  logic [15:0] alu_a,
    input  logic [15:0] alu_b,
    output logic [15:0] alu_out,
    output logic        en_out,
    output logic        busy,
    output logic [3:0]  flags
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    localparam logic [3:0] OP_MOV = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;
    localparam logic [3:0] OP_INC = 4'b1010;
    localparam logic [3:0] OP_DEC = 4'b1011;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] out_reg, out_next;
    logic [3:0]  flags_reg, flags_next;
    logic        en_out_reg, en_out_next;
    logic        busy_reg, busy_next;
    logic [31:0] acc_reg, acc_next;
    logic [31:0] mcand_reg, mcand_next;
    logic [15:0] mplr_reg, mplr_next;
    logic [3:0]  count_reg, count_next;

    // Single-cycle datapath, evaluated directly from the live inputs.
    logic [16:0] sum17, diff17, inc17, dec17;
    logic [31:0] shl32, shr32;
    logic [15:0] alu_res;
    logic        alu_c, alu_v;
    logic [3:0]  alu_flags;

    always_comb begin
        alu_res = 16'h0000;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        sum17   = {1'b0, alu_a} + {1'b0, alu_b};
        diff17  = {1'b0, alu_a} - {1'b0, alu_b};
        inc17   = {1'b0, alu_a} + 17'd1;
        dec17   = {1'b0, alu_a} - 17'd1;
        // The last bit shifted out lands just outside the kept half of each 32-bit window.
        shl32   = {16'h0000, alu_a} << alu_b[3:0];
        shr32   = {alu_a, 16'h0000} >> alu_b[3:0];
        case (alu_func)
            OP_ADD: begin
                alu_res = sum17[15:0];
                alu_c   = sum17[16];
                alu_v   = (alu_a[15] == alu_b[15]) && (sum17[15] != alu_a[15]);
            end
            OP_SUB: begin
                alu_res = diff17[15:0];
                alu_c   = diff17[16];
                alu_v   = (alu_a[15] != alu_b[15]) && (diff17[15] != alu_a[15]);
            end
            OP_AND: alu_res = alu_a & alu_b;
            OP_OR:  alu_res = alu_a | alu_b;
            OP_XOR: alu_res = alu_a ^ alu_b;
            OP_NOT: alu_res = ~alu_a;
            OP_SHL: begin
                alu_res = shl32[15:0];
                alu_c   = shl32[16];
            end
            OP_SHR: begin
                alu_res = shr32[31:16];
                alu_c   = shr32[15];
            end
            OP_MOV: alu_res = alu_b;
            OP_INC: begin
                alu_res = inc17[15:0];
                alu_c   = inc17[16];
                alu_v   = ~alu_a[15] & inc17[15];
            end
            OP_DEC: begin
                alu_res = dec17[15:0];
                alu_c   = dec17[16];
                alu_v   = alu_a[15] & ~dec17[15];
            end
            default: begin
                alu_res = 16'h0000;
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
        endcase
        alu_flags = {alu_res[15], (alu_res == 16'h0000), alu_c, alu_v};
    end

    // One shift-add step per cycle; the final step's sum is the product.
    logic [31:0] mul_sum;
    logic [3:0]  mul_flags;

    always_comb begin
        mul_sum   = acc_reg + (mplr_reg[0] ? mcand_reg : 32'h0000_0000);
        mul_flags = {mul_sum[15], (mul_sum[15:0] == 16'h0000), (mul_sum[31:16] != 16'h0000), 1'b0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            out_reg    <= 16'h0000;
            flags_reg  <= 4'h0;
            en_out_reg <= 1'b0;
            busy_reg   <= 1'b0;
            acc_reg    <= 32'h0000_0000;
            mcand_reg  <= 32'h0000_0000;
            mplr_reg   <= 16'h0000;
            count_reg  <= 4'h0;
        end else begin
            state_reg  <= state_next;
            out_reg    <= out_next;
            flags_reg  <= flags_next;
            en_out_reg <= en_out_next;
            busy_reg   <= busy_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplr_reg   <= mplr_next;
            count_reg  <= count_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        out_next    = out_reg;
        flags_next  = flags_reg;
        en_out_next = 1'b0;
        busy_next   = busy_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplr_next   = mplr_reg;
        count_next  = count_reg;
        case (state_reg)
            S_IDLE: begin
                if (en_in) begin
                    if (alu_func == OP_MUL) begin
                        state_next = S_MUL;
                        busy_next  = 1'b1;
                        acc_next   = 32'h0000_0000;
                        mcand_next = {16'h0000, alu_a};
                        mplr_next  = alu_b;
                        count_next = 4'h0;
                    end else begin
                        out_next    = alu_res;
                        flags_next  = alu_flags;
                        en_out_next = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_next   = mul_sum;
                mcand_next = {mcand_reg[30:0], 1'b0};
                mplr_next  = {1'b0, mplr_reg[15:1]};
                count_next = count_reg + 4'd1;
                if (count_reg == 4'hF) begin
                    state_next  = S_IDLE;
                    busy_next   = 1'b0;
                    out_next    = mul_sum[15:0];
                    flags_next  = mul_flags;
                    en_out_next = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign alu_out = out_reg;
    assign flags   = flags_reg;
    assign en_out  = en_out_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed corner cases plus randomized ops against an arithmetic model.
module tb_alu_exec;

    logic        clk;
    logic        rst;
    logic        en_in;
    logic [3:0]  alu_func;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_out;
    logic        en_out;
    logic        busy;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;
    logic [19:0] last_exp;   // {flags, alu_out} currently expected on the outputs

    alu_exec dut (
        .clk      (clk),
        .rst      (rst),
        .en_in    (en_in),
        .alu_func (alu_func),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_out  (alu_out),
        .en_out   (en_out),
        .busy     (busy),
        .flags    (flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // Reference: plain integer arithmetic on the operands; returns {N,Z,C,V, result}.
    function automatic logic [19:0] model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        longint ua, ub, sa, sb, r, s;
        int n;
        bit c, v;
        logic [15:0] res;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        n = b % 16;
        c = 0; v = 0; r = 0; s = 0;
        case (f)
            4'd0:  begin r = ua + ub; c = (r > 65535); s = sa + sb; v = (s > 32767) || (s < -32768); end
            4'd1:  begin r = ua - ub; c = (ua < ub);   s = sa - sb; v = (s > 32767) || (s < -32768); end
            4'd2:  r = ua & ub;
            4'd3:  r = ua | ub;
            4'd4:  r = ua ^ ub;
            4'd5:  r = 65535 - ua;
            4'd6:  begin r = ua * (64'd1 << n); c = (n > 0) && (((ua >> (16 - n)) & 1) != 0); end
            4'd7:  begin r = ua >> n;           c = (n > 0) && (((ua >> (n - 1)) & 1) != 0); end
            4'd8:  r = ub;
            4'd9:  begin r = ua * ub; c = (r > 65535); end
            4'd10: begin r = ua + 1; c = (r > 65535); s = sa + 1; v = (s > 32767); end
            4'd11: begin r = ua - 1; c = (ua == 0);   s = sa - 1; v = (s < -32768); end
            default: r = 0;
        endcase
        res = r[15:0];
        return {res[15], (res == 16'h0000), c, v, res};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; leaves the bench two negedges later with en_in low.
    task automatic run_single(input string tag, input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        logic [19:0] e;
        e = model(f, a, b);
        en_in = 1'b1; alu_func = f; alu_a = a; alu_b = b;
        @(negedge clk);
        en_in = 1'b0;
        check({tag, " en_out"}, {15'd0, en_out}, 16'd1);
        check({tag, " result"}, alu_out, e[15:0]);
        check({tag, " flags"}, {12'd0, flags}, {12'd0, e[19:16]});
        $display("op %s f=%h a=%h b=%h -> out=%h flags=%b", tag, f, a, b, alu_out, flags);
        last_exp = e;
        @(negedge clk);
        check({tag, " en_out drop"}, {15'd0, en_out}, 16'd0);
        check({tag, " hold"}, alu_out, e[15:0]);
    endtask

    // Called at a negedge; scrambles en_in and operands while busy, which must be ignored.
    task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b);
        logic [19:0] e;
        e = model(4'd9, a, b);
        en_in = 1'b1; alu_func = 4'd9; alu_a = a; alu_b = b;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check({tag, " busy"}, {15'd0, busy}, 16'd1);
            check({tag, " no en_out while busy"}, {15'd0, en_out}, 16'd0);
            en_in    = ((i % 3) == 0) || ($urandom_range(0, 1) == 1);
            alu_func = 4'($urandom_range(0, 15));
            alu_a    = 16'($urandom);
            alu_b    = 16'($urandom);
        end
        @(negedge clk);
        en_in = 1'b0;
        check({tag, " busy done"}, {15'd0, busy}, 16'd0);
        check({tag, " en_out"}, {15'd0, en_out}, 16'd1);
        check({tag, " result"}, alu_out, e[15:0]);
        check({tag, " flags"}, {12'd0, flags}, {12'd0, e[19:16]});
        $display("mul %s a=%h b=%h -> out=%h flags=%b", tag, a, b, alu_out, flags);
        last_exp = e;
        @(negedge clk);
        check({tag, " single pulse"}, {15'd0, en_out}, 16'd0);
    endtask

    initial begin
        logic [19:0] pend_exp;
        logic        pend;
        logic [3:0]  f;

        rst = 1'b0; en_in = 1'b0; alu_func = 4'd0; alu_a = 16'd0; alu_b = 16'd0;
        last_exp = 20'd0;
        @(negedge clk);
        check("reset alu_out", alu_out, 16'h0000);
        check("reset flags", {12'd0, flags}, 16'h0000);
        check("reset en_out", {15'd0, en_out}, 16'd0);
        check("reset busy", {15'd0, busy}, 16'd0);
        rst = 1'b1;

        run_single("add_ovf", 4'd0, 16'h7FFF, 16'h0001);
        check("add_ovf nzcv", {12'd0, flags}, 16'b1001);
        run_single("sub_borrow", 4'd1, 16'h0003, 16'h0005);
        check("sub_borrow nzcv", {12'd0, flags}, 16'b1010);
        run_single("sub_zero", 4'd1, 16'h1234, 16'h1234);
        check("sub_zero value", alu_out, 16'h0000);
        run_single("shl_out", 4'd6, 16'h8001, 16'h0001);
        check("shl_out value", alu_out, 16'h0002);
        run_single("shr_zero_amt", 4'd7, 16'h0001, 16'h0000);
        check("shr_zero_amt value", alu_out, 16'h0001);
        run_single("inc_wrap", 4'd10, 16'hFFFF, 16'h0000);
        run_single("dec_ovf", 4'd11, 16'h8000, 16'h0000);
        run_single("dec_zero", 4'd11, 16'h0000, 16'h0000);
        run_single("not", 4'd5, 16'h00F0, 16'h0000);
        run_single("mov", 4'd8, 16'h0000, 16'hBEEF);
        run_single("bad_code", 4'd13, 16'h1234, 16'h5678);
        check("bad_code nzcv", {12'd0, flags}, 16'b0100);

        run_mul("mul_big", 16'h0100, 16'h0100);
        check("mul_big nzcv", {12'd0, flags}, 16'b0110);
        // Accept immediately after completion.
        run_single("after_mul", 4'd0, 16'h0010, 16'h0020);
        run_mul("mul_small", 16'h0003, 16'h0007);
        check("mul_small value", alu_out, 16'h0015);
        for (int i = 0; i < 4; i++) begin
            run_mul("mul_rand", 16'($urandom), 16'($urandom));
        end
        run_mul("mul_small2", 16'h0003, 16'h0007);

        // Abort a multiply with reset part-way through.
        en_in = 1'b1; alu_func = 4'd9; alu_a = 16'h1234; alu_b = 16'h5678;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            en_in = 1'b0;
        end
        rst = 1'b0;
        #1;
        check("rst_abort alu_out", alu_out, 16'h0000);
        check("rst_abort flags", {12'd0, flags}, 16'h0000);
        check("rst_abort en_out", {15'd0, en_out}, 16'd0);
        check("rst_abort busy", {15'd0, busy}, 16'd0);
        $display("reset during mul -> out=%h flags=%b busy=%b", alu_out, flags, busy);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("post_abort en_out", {15'd0, en_out}, 16'd0);
            check("post_abort busy", {15'd0, busy}, 16'd0);
        end
        run_single("add_after_rst", 4'd0, 16'h0001, 16'h0001);
        check("add_after_rst value", alu_out, 16'h0002);

        // Back-to-back logic ops.
        en_in = 1'b1; alu_a = 16'h00FF; alu_b = 16'h0F0F;
        alu_func = 4'd2;
        @(negedge clk);
        check("b2b and en_out", {15'd0, en_out}, 16'd1);
        check("b2b and", alu_out, 16'h000F);
        $display("b2b and -> out=%h", alu_out);
        alu_func = 4'd3;
        @(negedge clk);
        check("b2b or en_out", {15'd0, en_out}, 16'd1);
        check("b2b or", alu_out, 16'h0FFF);
        $display("b2b or -> out=%h", alu_out);
        alu_func = 4'd4;
        @(negedge clk);
        en_in = 1'b0;
        check("b2b xor en_out", {15'd0, en_out}, 16'd1);
        check("b2b xor", alu_out, 16'h0FF0);
        $display("b2b xor -> out=%h", alu_out);
        last_exp = model(4'd4, 16'h00FF, 16'h0F0F);
        @(negedge clk);
        check("b2b end en_out", {15'd0, en_out}, 16'd0);

        // Random single-cycle stream with gaps; outputs must hold across idle cycles.
        for (int i = 0; i < 200; i++) begin
            f = 4'($urandom_range(0, 15));
            if (f == 4'd9) f = 4'd0;
            pend     = ($urandom_range(0, 3) != 0);
            en_in    = pend;
            alu_func = f;
            alu_a    = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
            alu_b    = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            pend_exp = model(f, alu_a, alu_b);
            @(negedge clk);
            if (pend) last_exp = pend_exp;
            check("rand en_out", {15'd0, en_out}, {15'd0, pend});
            check("rand result", alu_out, last_exp[15:0]);
            check("rand flags", {12'd0, flags}, {12'd0, last_exp[19:16]});
            $display("rand %0d en=%b f=%h -> out=%h flags=%b", i, pend, f, alu_out, flags);
        end
        en_in = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 16 bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 en_in  input  1  operand-valid strobe from the register-file stage (its en_out), active-high.
REQ-005 alu_func  input  4  operation code, sampled with en_in.
REQ-006 alu_a  input  16  first operand (register-file rd_q).
REQ-007 alu_b  input  16  second operand (register-file rs_q).
REQ-008 alu_out  output  16  registered result; feeds register-file d_in.
REQ-009 en_out  output  1  result-valid, one-cycle pulse per accepted operation.
REQ-010 busy  output  1  high while a multi-cycle operation is executing.
REQ-011 flags  output  4  registered {N,Z,C,V}, updated together with alu_out.

Function
REQ-012 States SHALL be IDLE and MUL; reset enters IDLE.
REQ-013 In IDLE with en_in=1 at a rising edge, the block SHALL latch alu_func/alu_a/alu_b at that edge.
REQ-014 Single-cycle ops SHALL update alu_out/flags at the accepting edge and drive en_out=1 for exactly the following cycle.
REQ-015 Op codes: 0000 ADD a+b; 0001 SUB a-b; 0010 AND; 0011 OR; 0100 XOR; 0101 NOT a; 0110 SHL a by b[3:0]; 0111 SHR (logical) a by b[3:0]; 1000 MOV b; 1001 MUL; 1010 INC a; 1011 DEC a.
REQ-016 Codes 1100-1111 SHALL produce alu_out=0x0000, flags N=0 Z=1 C=0 V=0, with single-cycle timing.
REQ-017 Z SHALL be 1 iff the 16-bit result is 0; N SHALL equal result bit 15, for every op.
REQ-018 ADD/INC: C=carry out of bit 15; SUB/DEC: C=1 iff unsigned borrow (a<b, or a=0 for DEC).
REQ-019 V SHALL be signed two's-complement overflow for ADD/SUB/INC/DEC and 0 for all other ops.
REQ-020 SHL/SHR: C = last bit shifted out; shift amount 0 gives result=a, C=0.
REQ-021 Logic ops, NOT, MOV: C=0, V=0.
REQ-022 MUL SHALL be iterative shift-add over 16 cycles: accept edge k enters MUL with busy=1; result written at edge k+16; en_out=1 in the cycle after edge k+16; busy=0 from edge k+16.
REQ-023 MUL alu_out SHALL be product bits [15:0] (unsigned); C=1 iff product bits [31:16] nonzero; V=0.
REQ-024 en_in asserted while busy=1 SHALL be ignored (dropped, not queued); en_in in the cycle after MUL completes SHALL be accepted normally.
REQ-025 Back-to-back single-cycle ops (en_in high on consecutive edges) SHALL each be accepted, giving en_out high continuously with one result per cycle.
REQ-026 alu_out and flags SHALL hold their last value between operations; en_out SHALL be 0 whenever no result is being presented.
REQ-027 Operand changes after the accepting edge SHALL NOT affect an in-progress MUL.

Reset
REQ-028 rst=0 SHALL immediately force alu_out=0x0000, flags=0000, en_out=0, busy=0, state IDLE, multiplier accumulator/counter cleared.
REQ-029 Reset during MUL SHALL abort it with no en_out pulse after rst deasserts.
REQ-030 The first operation SHALL be accepted at the first rising edge with rst=1 and en_in=1.

Verification
REQ-031 ADD a=0x7FFF b=0x0001 -> next cycle alu_out=0x8000, en_out=1 for one cycle, N=1 Z=0 C=0 V=1.
REQ-032 SUB a=0x0003 b=0x0005 -> alu_out=0xFFFE, N=1 Z=0 C=1 V=0; SUB a=b=0x1234 -> 0x0000, Z=1.
REQ-033 SHL a=0x8001 b=0x0001 -> alu_out=0x0002, C=1; SHR a=0x0001 b=0x0000 -> alu_out=0x0001, C=0.
REQ-034 MUL a=0x0100 b=0x0100 -> busy high 16 cycles, en_in pulses during busy ignored, then alu_out=0x0000, Z=1 C=1, single en_out pulse; MUL 0x0003x0x0007 -> 0x0015, C=0.
REQ-035 Start MUL, pull rst low at cycle 8 -> all outputs 0 at once, no en_out after release; next ADD 0x0001+0x0001 -> 0x0002.
REQ-036 Three consecutive en_in cycles AND/OR/XOR with a=0x00FF b=0x0F0F -> en_out high 3 cycles, results 0x000F, 0x0FFF, 0x0FF0 in order.
